// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage of the RV32 core.
//
// Formats sub-word loads and stores and generates their byte strobes. It flags
// misaligned and illegal accesses. The address region decides where an access
// goes: cached accesses use the word-level d_cache port, and uncached accesses
// use a timeout-guarded MMIO handshake FSM. Results are registered into the
// MEM/WB pipeline register under enable/flush control.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   *_mem_i                       EX/MEM pipeline inputs (address, store data,
//                                 passthroughs, funct3, store flag, valid)
//   enable_i, reset_i             MEM/WB advance and flush (flush needs enable_i)
//   stall_by_icache_i             blocks issue of new requests
//   dc_*                          d_cache request/response port
//   io_*                          uncached MMIO request/response port
//   stall_o                       freezes earlier pipeline stages
//   *_wb_o                        MEM/WB pipeline register outputs
//   exc_wb_o                      {bus timeout, misaligned/illegal}
module mem_access_unit #(
    parameter int unsigned REGION_BITS   = 3,
    parameter int unsigned CACHED_REGION = 0,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] alu_mem_i,
    input  logic [31:0] rs2_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic [31:0] inst_mem_i,
    input  logic [2:0]  funct3_mem_i,
    input  logic        MemRW_mem_i,
    input  logic        mem_valid_i,
    input  logic [1:0]  WBSel_mem_i,
    input  logic        RegWEn_mem_i,
    input  logic [4:0]  rsW_mem_i,
    input  logic        enable_i,
    input  logic        reset_i,
    input  logic        stall_by_icache_i,
    output logic        dc_req_valid_o,
    output logic [31:0] dc_addr_o,
    output logic [31:0] dc_wdata_o,
    output logic [3:0]  dc_wstrb_o,
    output logic        dc_we_o,
    input  logic        dc_ready_i,
    input  logic [31:0] dc_rdata_i,
    output logic        io_cs_o,
    output logic        io_we_o,
    output logic [31:0] io_addr_o,
    output logic [31:0] io_wdata_o,
    output logic [3:0]  io_wstrb_o,
    input  logic        io_rvalid_i,
    input  logic [31:0] io_rdata_i,
    output logic        stall_o,
    output logic [31:0] alu_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [31:0] mem_wb_o,
    output logic [31:0] inst_wb_o,
    output logic [1:0]  WBSel_wb_o,
    output logic        RegWEn_wb_o,
    output logic [4:0]  rsW_wb_o,
    output logic [1:0]  exc_wb_o
);

    // The counter only needs to reach TIMEOUT-1: the BUSY cycle holding that
    // value is the TIMEOUT-th one, after which the access is declared dead.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [REGION_BITS-1:0] CACHED_TAG = REGION_BITS'(CACHED_REGION);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Load data alignment and sign/zero extension.
    function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_fmt = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_fmt = {24'h000000, sh[7:0]};
            3'b101:  load_fmt = {16'h0000, sh[15:0]};
            default: load_fmt = sh;
        endcase
    endfunction

    // Byte strobes for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                              input logic [1:0] off);
        case (f3)
            3'b000:  store_strb = 4'b0001 << off;
            3'b001:  store_strb = 4'b0011 << off;
            3'b010:  store_strb = 4'b1111;
            default: store_strb = 4'b0000;
        endcase
    endfunction

    // Store data replicated across the lanes so any strobe picks the right bytes.
    function automatic logic [31:0] store_data(input logic [31:0] rs2,
                                               input logic [2:0]  f3);
        case (f3)
            3'b000:  store_data = {4{rs2[7:0]}};
            3'b001:  store_data = {2{rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    state_e           state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [31:0]      hold_r, hold_n;
    logic             err_r, err_n;
    logic             kill_r, kill_n;

    logic        access_s;
    logic        cached_s;
    logic        illegal_s;
    logic        misaligned_s;
    logic        fault_s;
    logic        issue_s;
    logic        dc_req_s;
    logic        io_cs_s;
    logic        fsm_stall_s;
    logic        flush_s;
    logic        kill_now_s;
    logic        bus_err_s;
    logic [3:0]  wstrb_s;
    logic [31:0] wdata_s;
    logic [31:0] mem_data_s;

    assign access_s = mem_valid_i & ~stall_by_icache_i;
    assign cached_s = (alu_mem_i[31 -: REGION_BITS] == CACHED_TAG);
    assign flush_s  = enable_i & reset_i;

    // Illegal funct3 / misalignment decode.
    always_comb begin
        illegal_s    = 1'b0;
        misaligned_s = 1'b0;
        case (funct3_mem_i)
            3'b000:  begin illegal_s = 1'b0;        misaligned_s = 1'b0; end
            3'b001:  begin illegal_s = 1'b0;        misaligned_s = alu_mem_i[0]; end
            3'b010:  begin illegal_s = 1'b0;        misaligned_s = (alu_mem_i[1:0] != 2'b00); end
            3'b100:  begin illegal_s = MemRW_mem_i; misaligned_s = 1'b0; end
            3'b101:  begin illegal_s = MemRW_mem_i; misaligned_s = alu_mem_i[0]; end
            default: begin illegal_s = 1'b1;        misaligned_s = 1'b0; end
        endcase
    end

    assign fault_s = illegal_s | misaligned_s;
    assign issue_s = access_s & ~cached_s & ~fault_s;
    assign dc_req_s = access_s & cached_s & ~fault_s;

    assign wstrb_s = MemRW_mem_i ? store_strb(funct3_mem_i, alu_mem_i[1:0]) : 4'b0000;
    assign wdata_s = store_data(rs2_mem_i, funct3_mem_i);

    assign dc_req_valid_o = dc_req_s;
    assign dc_addr_o      = alu_mem_i;
    assign dc_wdata_o     = wdata_s;
    assign dc_wstrb_o     = wstrb_s;
    assign dc_we_o        = MemRW_mem_i;

    // EX/MEM is frozen by stall_o while BUSY, so these stay stable.
    assign io_cs_o    = io_cs_s;
    assign io_we_o    = MemRW_mem_i;
    assign io_addr_o  = alu_mem_i;
    assign io_wdata_o = wdata_s;
    assign io_wstrb_o = wstrb_s;

    assign stall_o = fsm_stall_s | (dc_req_s & ~dc_ready_i);

    // A flush in the same cycle as the response must still suppress DONE.
    assign kill_now_s = kill_r | flush_s;
    assign bus_err_s  = (state_r == ST_DONE) & err_r;
    assign mem_data_s = (state_r == ST_DONE) ? load_fmt(hold_r, funct3_mem_i, alu_mem_i[1:0])
                                             : load_fmt(dc_rdata_i, funct3_mem_i, alu_mem_i[1:0]);

    // Uncached handshake FSM: next state, counter, hold/error/kill and outputs.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        hold_n      = hold_r;
        err_n       = err_r;
        kill_n      = kill_r;
        io_cs_s     = 1'b0;
        fsm_stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    io_cs_s     = 1'b1;
                    fsm_stall_s = 1'b1;
                    cnt_n       = {CNT_W{1'b0}};
                    kill_n      = 1'b0;
                    state_n     = ST_BUSY;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                fsm_stall_s = 1'b1;
                cnt_n       = cnt_r + CNT_W'(1);
                kill_n      = kill_now_s;
                if (io_rvalid_i) begin
                    hold_n  = io_rdata_i;
                    err_n   = 1'b0;
                    kill_n  = 1'b0;
                    state_n = kill_now_s ? ST_IDLE : ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    hold_n  = 32'h0000_0000;
                    err_n   = 1'b1;
                    kill_n  = 1'b0;
                    state_n = kill_now_s ? ST_IDLE : ST_DONE;
                end else begin
                    state_n = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (enable_i) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                kill_n  = 1'b0;
            end
        endcase
    end

    // FSM state, timeout counter, response hold, error and kill flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            hold_r  <= 32'h0000_0000;
            err_r   <= 1'b0;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            hold_r  <= hold_n;
            err_r   <= err_n;
            kill_r  <= kill_n;
        end
    end

    // MEM/WB pipeline register with flush and advance control.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alu_wb_o    <= 32'h0000_0000;
            pc4_wb_o    <= 32'h0000_0000;
            mem_wb_o    <= 32'h0000_0000;
            inst_wb_o   <= 32'h0000_0000;
            WBSel_wb_o  <= 2'b00;
            RegWEn_wb_o <= 1'b0;
            rsW_wb_o    <= 5'd0;
            exc_wb_o    <= 2'b00;
        end else if (flush_s) begin
            alu_wb_o    <= 32'h0000_0000;
            pc4_wb_o    <= 32'h0000_0000;
            mem_wb_o    <= 32'h0000_0000;
            inst_wb_o   <= 32'h0000_0000;
            WBSel_wb_o  <= 2'b00;
            RegWEn_wb_o <= 1'b0;
            rsW_wb_o    <= 5'd0;
            exc_wb_o    <= 2'b00;
        end else if (enable_i) begin
            alu_wb_o    <= alu_mem_i;
            pc4_wb_o    <= pc4_mem_i;
            mem_wb_o    <= mem_data_s;
            inst_wb_o   <= inst_mem_i;
            WBSel_wb_o  <= WBSel_mem_i;
            RegWEn_wb_o <= RegWEn_mem_i & ~fault_s & ~bus_err_s;
            rsW_wb_o    <= rsW_mem_i;
            exc_wb_o    <= {bus_err_s, fault_s & access_s};
        end
    end

endmodule
